// File: rtl/v35_intc_pkg.sv
// Shared types and constants for the V35 interrupt scheduler.
// Source order and vector numbers follow the V35 INTP0-2 / TMU0-2 assignment.
package v35_intc_pkg;

  localparam int NUM_SRC      = 6;
  localparam int VEC_BASE     = 24;
  localparam int TMU_VEC_BASE = 28;

  localparam logic [7:0] NMI_VEC   = 8'd2;
  localparam logic [7:0] XIC_RESET = 8'h47;

  localparam int XIC_IF     = 7;
  localparam int XIC_MK     = 6;
  localparam int XIC_PR_MSB = 2;
  localparam int XIC_PR_LSB = 0;

  localparam logic [2:0] SEL_ISPR = 3'd6;

  typedef enum logic [2:0] {
    SRC_INTP0, SRC_INTP1, SRC_INTP2, SRC_TMU0, SRC_TMU1, SRC_TMU2
  } src_e;

  typedef enum logic {IDLE, PEND} state_e;

  typedef logic [2:0] pr_t;

  function automatic logic [7:0] src_vec(input logic [2:0] idx);
    if (idx < SRC_TMU0) return 8'(VEC_BASE) + {5'd0, idx};
    else                return 8'(TMU_VEC_BASE) + {5'd0, idx} - 8'd3;
  endfunction

  // ISPR bits 0..pr inclusive: every level at or above priority pr.
  function automatic logic [7:0] level_mask(input pr_t pr);
    return 8'((9'd2 << pr) - 9'd1);
  endfunction

endpackage

// File: rtl/v35_intc_if.sv
// Core-side bus of the V35 interrupt scheduler: source events, indexed
// register port and the irq request/ack/fini handshake.
interface v35_intc_if;
  import v35_intc_pkg::*;

  logic [NUM_SRC-1:0] src_event;
  logic               reg_wr;
  logic [2:0]         reg_sel;
  logic [7:0]         reg_din;
  logic [7:0]         reg_dout;
  logic               irq_req;
  logic [7:0]         irq_vec;
  logic               irq_ack;
  logic               irq_fini;

  modport master (
    output src_event, reg_wr, reg_sel, reg_din, irq_ack, irq_fini,
    input  reg_dout, irq_req, irq_vec
  );

  modport slave (
    input  src_event, reg_wr, reg_sel, reg_din, irq_ack, irq_fini,
    output reg_dout, irq_req, irq_vec
  );
endinterface

// File: rtl/v35_intc_arb.sv
// Combinational eligibility and priority select: lowest PR wins, ties go to
// the lowest source index; sources at or below an in-service level are held off.
module v35_intc_arb
  import v35_intc_pkg::*;
(
  input  logic [NUM_SRC-1:0] if_flag,
  input  logic [NUM_SRC-1:0] mk,
  input  pr_t                pr [NUM_SRC],
  input  logic [7:0]         ispr,
  output logic               valid,
  output logic [2:0]         idx,
  output pr_t                win_pr
);

  logic [NUM_SRC-1:0] elig;

  always_comb begin
    // NOTE: every output gets a default before the loops so no path infers a latch.
    valid  = 1'b0;
    idx    = '0;
    win_pr = '0;
    elig   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = if_flag[i] && !mk[i] && ((ispr & level_mask(pr[i])) == 8'h00);
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && (!valid || (pr[i] < win_pr))) begin
        valid  = 1'b1;
        idx    = 3'(i);
        win_pr = pr[i];
      end
    end
  end

endmodule

// File: rtl/v35_intc.sv
// V35 interrupt scheduler: xIC/ISPR registers, arbitration and the committed
// request handshake. Optional NMI input enabled by V35_INTC_NMI_EN.
module v35_intc
  import v35_intc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ce_cycle,
`ifdef V35_INTC_NMI_EN
  input  logic nmi,
`endif
  v35_intc_if.slave bus
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] if_q, if_d, mk_q, mk_d;
  pr_t                pr_q [NUM_SRC];
  pr_t                pr_d [NUM_SRC];
  logic [7:0]         ispr_q, ispr_d;
  logic [2:0]         lat_idx_q, lat_idx_d;
  pr_t                lat_pr_q, lat_pr_d;
  logic               irq_req_q, irq_req_d;
  logic [7:0]         irq_vec_q, irq_vec_d;
`ifdef V35_INTC_NMI_EN
  logic               nmi_pend_q, nmi_pend_d;
  logic               nmi_prev_q, nmi_prev_d;
  logic               lat_nmi_q, lat_nmi_d;
`endif

  logic               arb_valid;
  logic [2:0]         arb_idx;
  pr_t                arb_pr;
  logic [7:0]         rd_data;

  v35_intc_arb u_arb (
    .if_flag (if_q),
    .mk      (mk_q),
    .pr      (pr_q),
    .ispr    (ispr_q),
    .valid   (arb_valid),
    .idx     (arb_idx),
    .win_pr  (arb_pr)
  );

  always_comb begin
    state_d   = state_q;
    if_d      = if_q;
    mk_d      = mk_q;
    pr_d      = pr_q;
    ispr_d    = ispr_q;
    lat_idx_d = lat_idx_q;
    lat_pr_d  = lat_pr_q;
    irq_req_d = irq_req_q;
    irq_vec_d = irq_vec_q;
`ifdef V35_INTC_NMI_EN
    nmi_pend_d = nmi_pend_q;
    nmi_prev_d = nmi_prev_q;
    lat_nmi_d  = lat_nmi_q;
`endif

    if (bus.reg_wr) begin
      if (bus.reg_sel < 3'(NUM_SRC)) begin
        if_d[bus.reg_sel] = bus.reg_din[XIC_IF];
        mk_d[bus.reg_sel] = bus.reg_din[XIC_MK];
        pr_d[bus.reg_sel] = bus.reg_din[XIC_PR_MSB:XIC_PR_LSB];
      end else if (bus.reg_sel == SEL_ISPR) begin
        ispr_d = bus.reg_din;
      end
    end

    if (ce_cycle) begin
      // fini retires the highest in-service level before any ack adds a new one
      if (bus.irq_fini) ispr_d = ispr_d & (ispr_d - 8'd1);

      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            lat_idx_d = arb_idx;
            lat_pr_d  = arb_pr;
            irq_vec_d = src_vec(arb_idx);
            irq_req_d = 1'b1;
            state_d   = PEND;
          end
`ifdef V35_INTC_NMI_EN
          lat_nmi_d = nmi_pend_q;
          if (nmi_pend_q) begin
            irq_vec_d = NMI_VEC;
            irq_req_d = 1'b1;
            state_d   = PEND;
          end
`endif
        end
        PEND: begin
          if (bus.irq_ack) begin
`ifdef V35_INTC_NMI_EN
            if (lat_nmi_q) nmi_pend_d = 1'b0;
            else
`endif
            begin
              ispr_d[lat_pr_q] = 1'b1;
              if_d[lat_idx_q]  = 1'b0;
            end
            irq_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      endcase

      // Events applied last so they beat both a register write and an ack clear.
      if_d = if_d | bus.src_event;
`ifdef V35_INTC_NMI_EN
      nmi_prev_d = nmi;
      if (nmi && !nmi_prev_q) nmi_pend_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      if_q      <= {NUM_SRC{XIC_RESET[XIC_IF]}};
      mk_q      <= {NUM_SRC{XIC_RESET[XIC_MK]}};
      for (int i = 0; i < NUM_SRC; i++) pr_q[i] <= XIC_RESET[XIC_PR_MSB:XIC_PR_LSB];
      ispr_q    <= 8'h00;
      lat_idx_q <= '0;
      lat_pr_q  <= '0;
      irq_req_q <= 1'b0;
      irq_vec_q <= 8'h00;
`ifdef V35_INTC_NMI_EN
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b0;
      lat_nmi_q  <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use <= so every flop samples the pre-edge values.
      state_q   <= state_d;
      if_q      <= if_d;
      mk_q      <= mk_d;
      pr_q      <= pr_d;
      ispr_q    <= ispr_d;
      lat_idx_q <= lat_idx_d;
      lat_pr_q  <= lat_pr_d;
      irq_req_q <= irq_req_d;
      irq_vec_q <= irq_vec_d;
`ifdef V35_INTC_NMI_EN
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi_prev_d;
      lat_nmi_q  <= lat_nmi_d;
`endif
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (bus.reg_sel < 3'(NUM_SRC)) begin
      rd_data[XIC_IF]                 = if_q[bus.reg_sel];
      rd_data[XIC_MK]                 = mk_q[bus.reg_sel];
      rd_data[XIC_PR_MSB:XIC_PR_LSB]  = pr_q[bus.reg_sel];
    end else if (bus.reg_sel == SEL_ISPR) begin
      rd_data = ispr_q;
    end
  end

  assign bus.reg_dout = rd_data;
  assign bus.irq_req  = irq_req_q;
  assign bus.irq_vec  = irq_vec_q;

endmodule

// File: tb/tb_v35_intc.sv
// Self-checking bench for v35_intc: directed scenarios plus randomized traffic
// compared against a register-level behavioural model of the scheduler.
module tb_v35_intc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce_cycle = 1'b1;
  logic nmi = 1'b0;

  always #10 clk = ~clk;

  v35_intc_if bus();

  v35_intc dut (
    .clk      (clk),
    .reset    (reset),
    .ce_cycle (ce_cycle),
`ifdef V35_INTC_NMI_EN
    .nmi      (nmi),
`endif
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: register images plus the committed pending request.
  logic [7:0] m_xic [6];
  logic [7:0] m_ispr;
  bit         m_pend, m_req, m_nmi_lat, m_nmi_flag, m_nmi_prev;
  logic [7:0] m_vec;
  int         m_idx;
  logic [2:0] m_pr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit blocked(input logic [2:0] pr);
    for (int b = 0; b <= int'(pr); b++) if (m_ispr[b]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_vec(input int i);
    return (i < 3) ? 8'(24 + i) : 8'(28 + i - 3);
  endfunction

  function automatic logic [7:0] model_read(input int s);
    if (s < 6) return m_xic[s];
    if (s == 6) return m_ispr;
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_xic[i] = 8'h47;
    m_ispr = 8'h00; m_pend = 0; m_req = 0; m_vec = 8'h00;
    m_idx = 0; m_pr = 3'd0; m_nmi_lat = 0; m_nmi_flag = 0; m_nmi_prev = 0;
  endtask

  // One clk edge of the model, reading the inputs currently driven on the bus.
  task automatic model_step();
    int         win;
    logic [2:0] win_pr;
    bit         go_nmi;
    bit         done;
    win = -1;
    win_pr = 3'd0;
    go_nmi = !m_pend && m_nmi_flag;
    if (!m_pend) begin
      for (int p = 0; p < 8; p++)
        for (int i = 0; i < 6; i++)
          if (win < 0 && m_xic[i][7] && !m_xic[i][6] && int'(m_xic[i][2:0]) == p && !blocked(3'(p))) begin
            win = i;
            win_pr = 3'(p);
          end
    end
    if (bus.reg_wr) begin
      if (bus.reg_sel < 3'd6) m_xic[bus.reg_sel] = bus.reg_din & 8'hC7;
      else if (bus.reg_sel == 3'd6) m_ispr = bus.reg_din;
    end
    if (ce_cycle) begin
      if (bus.irq_fini) begin
        done = 0;
        for (int b = 0; b < 8; b++) if (!done && m_ispr[b]) begin m_ispr[b] = 1'b0; done = 1; end
      end
      if (!m_pend) begin
        if (go_nmi) begin
          m_pend = 1; m_nmi_lat = 1; m_req = 1; m_vec = 8'd2;
        end else if (win >= 0) begin
          m_pend = 1; m_nmi_lat = 0; m_req = 1; m_idx = win; m_pr = win_pr; m_vec = exp_vec(win);
        end
      end else if (bus.irq_ack) begin
        if (m_nmi_lat) m_nmi_flag = 0;
        else begin
          m_ispr[m_pr] = 1'b1;
          m_xic[m_idx][7] = 1'b0;
        end
        m_pend = 0; m_req = 0;
      end
      for (int i = 0; i < 6; i++) if (bus.src_event[i]) m_xic[i][7] = 1'b1;
      if (nmi && !m_nmi_prev) m_nmi_flag = 1;
      m_nmi_prev = nmi;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("irq_req", 32'(bus.irq_req), 32'(m_req));
    check("irq_vec", 32'(bus.irq_vec), 32'(m_vec));
    bus.src_event = '0; bus.reg_wr = 1'b0; bus.irq_ack = 1'b0; bus.irq_fini = 1'b0;
  endtask

  task automatic check_reg(input string tag, input int s, input logic [7:0] exp);
    bus.reg_sel = 3'(s);
    #1;
    check(tag, 32'(bus.reg_dout), 32'(exp));
  endtask

  task automatic check_regs();
    for (int s = 0; s < 8; s++) check_reg($sformatf("reg%0d", s), s, model_read(s));
  endtask

  task automatic wr(input int s, input logic [7:0] d);
    bus.reg_wr = 1'b1; bus.reg_sel = 3'(s); bus.reg_din = d;
    tick();
  endtask

  task automatic fini();
    bus.irq_fini = 1'b1;
    tick();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.irq_req && n < 20) begin tick(); n++; end
    check({tag, "_req"}, 32'(bus.irq_req), 32'd1);
  endtask

  task automatic serve(input string tag, input logic [7:0] vec);
    wait_req(tag);
    check({tag, "_vec"}, 32'(bus.irq_vec), 32'(vec));
    bus.irq_ack = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    bus.src_event = '0; bus.reg_wr = 1'b0; bus.reg_sel = 3'd0; bus.reg_din = 8'h00;
    bus.irq_ack = 1'b0; bus.irq_fini = 1'b0; ce_cycle = 1'b1; nmi = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check_regs();
    check("rst_req", 32'(bus.irq_req), 32'd0);
    check("rst_vec", 32'(bus.irq_vec), 32'd0);

    // Basic request: latency, vector, ISPR and IF after ack.
    wr(0, 8'h02);
    bus.src_event = 6'b000001; tick();
    check("t1_not_yet", 32'(bus.irq_req), 32'd0);
    tick();
    check("t1_req", 32'(bus.irq_req), 32'd1);
    check("t1_vec", 32'(bus.irq_vec), 32'd24);
    bus.irq_ack = 1'b1; tick();
    check_reg("t1_ispr", 6, 8'h04);
    check_reg("t1_exic0", 0, 8'h02);
    fini();

    // Priority and tie-break.
    wr(1, 8'h03); wr(3, 8'h01);
    bus.src_event = 6'b001010; tick();
    serve("t2a", 8'd28);
    fini();
    serve("t2b", 8'd25);
    fini();

    // In-service blocking and fini order.
    wr(6, 8'h02);
    bus.src_event = 6'b000010; tick(); tick(); tick();
    check("t3_blocked", 32'(bus.irq_req), 32'd0);
    wr(2, 8'h00);
    bus.src_event = 6'b000100; tick();
    serve("t3_pr0", 8'd26);
    check_reg("t3_ispr", 6, 8'h03);
    fini();
    check_reg("t3_fini", 6, 8'h02);
    fini();
    serve("t3_unblk", 8'd25);
    fini();

    // Masked source.
    bus.src_event = 6'b010000; tick(); tick(); tick();
    check_reg("t4_if", 4, 8'hC7);
    check("t4_noreq", 32'(bus.irq_req), 32'd0);
    wr(4, 8'h87);
    tick();
    check("t4_req", 32'(bus.irq_req), 32'd1);
    check("t4_vec", 32'(bus.irq_vec), 32'd29);
    bus.irq_ack = 1'b1; tick();
    fini();

    // Commit and simultaneous event/ack.
    wr(5, 8'h05);
    bus.src_event = 6'b100000; tick();
    wait_req("t5");
    wr(0, 8'h00);
    bus.src_event = 6'b000001; tick(); tick();
    check("t5_commit", 32'(bus.irq_vec), 32'd30);
    wr(5, 8'h83);
    check("t5_prwr", 32'(bus.irq_vec), 32'd30);
    bus.irq_ack = 1'b1; bus.src_event = 6'b100000; tick();
    check_reg("t5_ispr", 6, 8'h20);
    check_reg("t5_if", 5, 8'h83);
    serve("t5_src0", 8'd24);
    fini();
    serve("t5_repend", 8'd30);
    fini(); fini();
    check_regs();

    // Asynchronous reset while a request is pending.
    bus.src_event = 6'b010000; tick();
    wait_req("t6");
    #3;
    reset = 1'b1;
    #1;
    check("t6_async_rst", 32'(bus.irq_req), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_regs();

`ifdef V35_INTC_NMI_EN
    wr(6, 8'hFF);
    nmi = 1'b1; tick();
    wait_req("nmi");
    check("nmi_vec", 32'(bus.irq_vec), 32'd2);
    bus.irq_ack = 1'b1; tick();
    check_reg("nmi_ispr", 6, 8'hFF);
    nmi = 1'b0; tick();
    wr(6, 8'h00);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      ce_cycle = ($urandom % 4) != 0;
      bus.src_event = 6'($urandom & $urandom & $urandom);
      if ($urandom % 8 == 0) begin
        bus.reg_wr  = 1'b1;
        bus.reg_sel = 3'($urandom);
        bus.reg_din = 8'($urandom);
        if (bus.reg_sel == 3'd6) bus.reg_din = 8'($urandom & $urandom);
        else bus.reg_din[6] = ($urandom % 4) == 0;
      end
      bus.irq_ack  = m_pend ? 1'($urandom) : (($urandom % 10) == 0);
      bus.irq_fini = ($urandom % 5) == 0;
`ifdef V35_INTC_NMI_EN
      if ($urandom % 16 == 0) nmi = ~nmi;
`endif
      tick();
      if (i % 25 == 0) check_regs();
    end
    ce_cycle = 1'b1;
    check_regs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
